// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg
// Shared operation codes and FSM state type for the HI/LO multiply/divide
// unit; also used by the decoder and the stall unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;

  // Latency counter width; both latencies are limited to 1..15
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

endpackage : mdu_pkg

`default_nettype wire

// File: rtl/mdu_latency_counter.sv
// ============================================================================
// mdu_latency_counter
// Down-counter that times a multi-cycle operation: load N-1 on issue,
// decrement while running, done when the count has reached zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_latency_counter
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load on issue, otherwise count down to zero and hold there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule : mdu_latency_counter

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit
// Multi-cycle HI/LO multiply/divide unit for the EX stage. The result is
// computed at the issue edge, held internally, and committed to HI/LO when
// the latency counter expires, so HI/LO never change while busy is high.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [MD_OP_W-1:0]  md_op,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                busy,
  output logic [31:0]         HI,
  output logic [31:0]         LO
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t  state;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic        is_mul;
  logic        is_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] mul_res;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        issue;
  logic        cnt_done;

  // Full-width products from explicitly extended operands
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Classify the op and select the 64-bit multiply-family result
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    mul_res = 64'd0;
    case (md_op)
      MD_MULT: begin
        is_mul  = 1'b1;
        mul_res = prod_s;
      end
      MD_MULTU: begin
        is_mul  = 1'b1;
        mul_res = prod_u;
      end
`ifdef MDU_MADD_EN
      // Accumulate onto the HI/LO value committed at the issue edge
      MD_MADD: begin
        is_mul  = 1'b1;
        mul_res = {HI, LO} + prod_s;
      end
      MD_MADDU: begin
        is_mul  = 1'b1;
        mul_res = {HI, LO} + prod_u;
      end
`endif
      MD_DIV, MD_DIVU: begin
        is_div = 1'b1;
      end
      default: begin
        is_mul = 1'b0;
      end
    endcase
  end

  // Quotient/remainder with divide-by-zero and signed-overflow cases pinned
  always_comb begin
    div_q = 32'hFFFF_FFFF;
    div_r = A;
    if (B != 32'd0) begin
      if (md_op == MD_DIV) begin
        if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
          div_q = 32'h8000_0000;
          div_r = 32'd0;
        end else begin
          div_q = $signed(A) / $signed(B);
          div_r = $signed(A) % $signed(B);
        end
      end else begin
        div_q = A / B;
        div_r = A % B;
      end
    end
  end

  assign issue = (state == IDLE) && start && (is_mul || is_div);

  mdu_latency_counter u_latency (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (issue),
    .load_val (is_div ? DIV_LOAD : MUL_LOAD),
    .dec      (state != IDLE),
    .done     (cnt_done)
  );

  // Control FSM: issue, hold result while busy, commit to HI/LO on expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              res_hi <= mul_res[63:32];
              res_lo <= mul_res[31:0];
              busy   <= 1'b1;
              state  <= MUL;
            end else if (is_div) begin
              res_hi <= div_r;
              res_lo <= div_q;
              busy   <= 1'b1;
              state  <= DIV;
            end else if (md_op == MD_MTHI) begin
              HI <= A;
            end else if (md_op == MD_MTLO) begin
              LO <= A;
            end
          end
        end
        MUL, DIV: begin
          if (cnt_done) begin
            HI    <= res_hi;
            LO    <= res_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mult_div_unit

`default_nettype wire
